// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types, constants and helpers for the PS/2 host link
//             (transmitter and receiver side).
//  Contents : ps2_state_t    - host-to-device transmit state encoding
//             PS2_CMD_* / PS2_RESP_ACK - common keyboard command bytes
//             CNT_W          - width of the cycle counters
//             odd_parity()   - PS/2 parity bit for a data byte
//             sat_inc()      - saturating counter increment
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    RTS      = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAITIDLE = 3'd5
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // 20 bits hold the longest supported timeout (2^20-1 cycles).
  localparam int CNT_W = 20;

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Purpose  : Brings the asynchronous PS/2 clock and data pins into the
//             system clock domain and flags falling edges of the PS/2 clock.
//  Ports    : clk      in  system clock
//             rst      in  synchronous active-high reset
//             clk_pin  in  raw PS2_CLK pin level
//             dat_pin  in  raw PS2_DAT pin level
//             clk_sync out synchronized PS2_CLK
//             dat_sync out synchronized PS2_DAT
//             clk_fall out one-cycle pulse: synced clock went 1 -> 0
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Flops reset to 1 (idle bus level) so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pin};
      dat_ff   <= {dat_ff[0], dat_pin};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device byte transmitter. Inhibits the bus, issues
//             request-to-send, shifts out data/parity/stop on device clock
//             edges and checks the device ACK bit. Pins are open-drain:
//             driven low or released (z) only.
//  Ports    : CLOCK_50 in    system clock
//             reset    in    synchronous active-high reset
//             PS2_CLK  inout open-drain PS/2 clock
//             PS2_DAT  inout open-drain PS/2 data
//             cmd      in    byte to send, sampled on acceptance
//             send     in    transfer request, accepted when busy=0
//             busy     out   transfer in progress
//             done     out   one-cycle pulse at the end of every transfer
//             error    out   with done: no ACK or timeout
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic [7:0] cmd,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // The RTS cycle is the last of the INHIBIT_CYCLES clock-low cycles, so
  // INHIBIT hands over one count early: the counter shows INHIBIT_CYCLES-1
  // while in RTS. A one-cycle inhibit goes straight to RTS.
  localparam bit               INH_SHORT = (INHIBIT_CYCLES < 2);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state;
  logic [8:0]       shift;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic             clk_low;
  logic             dat_low;
  logic             ack_err;

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;
  logic timeout;

  ps2_line_sync u_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .clk_pin  (PS2_CLK),
    .dat_pin  (PS2_DAT),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  assign timeout = (cnt == TMO_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      clk_low <= 1'b0;
      dat_low <= 1'b0;
      ack_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if ((state == SHIFT || state == ACK) && timeout) begin
        // Device stopped clocking: abandon the frame and free the bus.
        clk_low <= 1'b0;
        dat_low <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
        error   <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (send) begin
              shift   <= {odd_parity(cmd), cmd};
              cnt     <= '0;
              bit_cnt <= '0;
              busy    <= 1'b1;
              clk_low <= 1'b1;
              if (INH_SHORT) begin
                dat_low <= 1'b1;
                state   <= RTS;
              end else begin
                state   <= INHIBIT;
              end
            end
          end
          INHIBIT: begin
            cnt <= sat_inc(cnt);
            if (cnt == INH_LAST) begin
              dat_low <= 1'b1;  // start bit
              state   <= RTS;
            end
          end
          RTS: begin
            clk_low <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          SHIFT: begin
            cnt <= sat_inc(cnt);
            if (clk_fall) begin
              if (bit_cnt == 4'd9) begin
                dat_low <= 1'b0;  // stop bit is the released line
                state   <= ACK;
              end else begin
                dat_low <= ~shift[bit_cnt];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ACK: begin
            cnt <= sat_inc(cnt);
            if (clk_fall) begin
              ack_err <= dat_sync;
              state   <= WAITIDLE;
            end
          end
          WAITIDLE: begin
            if (clk_sync && dat_sync) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= ack_err;
              state <= IDLE;
            end
          end
          default: begin
            clk_low <= 1'b0;
            dat_low <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  // Reset gates the drivers directly so the lines float from the first cycle
  // reset is high, not one clock later.
  assign PS2_CLK = (clk_low && !reset) ? 1'b0 : 1'bz;
  assign PS2_DAT = (dat_low && !reset) ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 byte transmitter, the send side of the keyboard link. It sends one command byte per request (for example 0xED "set LEDs" and then the LED mask), following the PS/2 host-to-device sequence:
- inhibit the clock;
- request-to-send;
- shift out the data bits, odd parity and stop bit on device-generated clock edges;
- check the device's line-level ACK bit.

It shares the open-drain `PS2_CLK`/`PS2_DAT` pins with the keyboard receiver and drives each line only low or high-Z.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low before request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: cycles allowed from clock release to ACK sampled (15 ms).

Ports (clock and reset first):
- `CLOCK_50`  in  1: system clock; one clock domain. Reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `PS2_CLK`  inout  1: open-drain; driven `0` or `z`.
- `PS2_DAT`  inout  1: open-drain; driven `0` or `z`.
- `cmd`  in  8: byte to send; sampled when `send` is accepted.
- `send`  in  1: request; accepted only when `busy`=0.
- `busy`  out  1: high from the cycle after acceptance until the cycle `done` pulses.
- `done`  out  1: one-cycle pulse at the end of every transfer, whether it succeeded or not.
- `error`  out  1: valid only with `done`; 1 means no ACK or timeout.

## Operation
- Pins are sampled through a 2-flop synchronizer. A falling edge of `PS2_CLK` is "synced previous = 1, synced current = 0".
- On acceptance, register a 9-bit shift value: `{~^cmd, cmd}`, i.e. odd parity in bit 8 and the data LSB first.
- States:
  - IDLE: both lines `z`. `send` → INHIBIT; latch `cmd`; clear the counter.
  - INHIBIT: `PS2_CLK`=0. When the counter reaches `INHIBIT_CYCLES`-1 → RTS.
  - RTS (one cycle): `PS2_DAT`=0 (start bit), `PS2_CLK`=0. Next cycle release `PS2_CLK`; clear the timeout counter; → SHIFT with bit counter = 0.
  - SHIFT: on each falling edge, bit counter 0..8 drives shift bit n (`0`→drive low, `1`→`z`). On the falling edge with counter 9, release `PS2_DAT` (stop bit) → ACK.
  - ACK: on the next falling edge, sample `PS2_DAT`. Synced 0 means ACK OK; 1 means error. → WAITIDLE.
  - WAITIDLE: wait until synced `PS2_CLK`=1 and `PS2_DAT`=1, then pulse `done` with `error` set from the ACK sample → IDLE.
- Timeout:
  - Runs during SHIFT and ACK.
  - At `TIMEOUT_CYCLES`, release both lines and pulse `done`=1 with `error`=1 in that cycle → IDLE. WAITIDLE is skipped.
- The 0xFA response byte is not checked here; it arrives through the receiver.
- `send` asserted while `busy`=1 is ignored and not queued.
- `cmd` changing after acceptance has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `PS2_CLK`=`z`, `PS2_DAT`=`z`, state IDLE, counters 0.
- Reset in any state: lines are `z` from the first cycle `reset` is seen high. No `done` pulse. The transfer is abandoned.
- Acceptance:
  - `send`=1 in IDLE at cycle T → `busy`=1 and `PS2_CLK`=0 at T+1.
  - Clock held low for exactly `INHIBIT_CYCLES` cycles.
  - `PS2_DAT`=0 asserted in the last inhibit cycle (RTS).
- Pin-to-drive latency: a data-line update follows the pin falling edge by 3 `CLOCK_50` cycles (2 synchronizer + 1 register). This is well within the device's half-period (≥30 µs).
- `done` and `busy` deassert in the same cycle. `send` can be accepted in the cycle after `done`.
- Counter widths: 20 bits cover `TIMEOUT_CYCLES` ≤ 2^20-1. Counters saturate and do not wrap.

## Structure
- Package `ps2_pkg`:
  - state enum {IDLE, INHIBIT, RTS, SHIFT, ACK, WAITIDLE};
  - constants `PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_RESP_ACK`=8'hFA.
- Sub-module `ps2_line_sync`: 2-flop synchronizer plus falling-edge detect for `PS2_CLK`, and a synced `PS2_DAT`. It is reused by the receiver.

## Test plan
- `cmd`=0xED with a device model clocking at 12.5 kHz and driving ACK → wire bits after the start bit are 1,0,1,1,0,1,1,1, parity 1, stop 1; then `done`=1, `error`=0.
- `cmd`=0x07 → parity bit 0.
- `cmd`=0x00 → parity bit 1.
- Both: `done`=1, `error`=0.
- Device clocks all 11 edges but leaves `PS2_DAT` high on the ACK edge → `done`=1, `error`=1, lines `z`.
- Device never clocks after RTS → `done`=1, `error`=1 exactly `TIMEOUT_CYCLES` after clock release; both lines `z`.
- `send` pulses while `busy` with `cmd`=0x55 → ignored; the original 0xED frame completes unchanged with exactly one `done`.
- `reset` asserted after bit 4 → next cycle both lines `z`, `busy`=0, no `done`. A new `send` then completes normally.
